unidade_busca: RTL
==================

Name: unidade_busca

Overview:
- Instruction-fetch front end; the initiator side of the instruction memory interface.
- Owns the fetch PC and drives the word address into the combinational instruction ROM (word-indexed, 32-bit words, returns 0 for out-of-range addresses).
- Captures each returned word with its PC into a small queue and hands the pairs to decode over a valid/ready handshake.
- Accepts branch redirects from execute; a redirect flushes the queue and restarts fetch at the target.

Parameters:
- PROF, 2: queue depth in entries; a power of two, at least 2.
- TAM_MEM, 64: instruction memory size in words; fetch stops at addresses >= TAM_MEM.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pc_mem  out  64  word address to the instruction memory.
- instrucao_mem  in  32  word returned by memory for pc_mem in the same cycle.
- instr_saida  out  32  instruction at the queue head.
- pc_saida  out  64  PC of the queue-head instruction.
- valido  out  1  queue head is valid.
- pronto  in  1  decode accepts the head this cycle.
- desvio  in  1  redirect request, one-cycle pulse.
- alvo  in  64  redirect target word address, sampled when desvio=1.
- parado  out  1  fetch has reached the end of memory and the queue is empty.

Behaviour:
- Interface: one clock, asynchronous active-low reset.
- Reset, asserted any time including mid-operation:
  - pc_busca=0, queue empty, count=0, state BUSCANDO.
  - valido=0, parado=0, instr_saida=0, pc_saida=0.
  - No partial state survives reset.
- Outputs:
  - pc_mem = pc_busca, combinational from the register.
  - instr_saida and pc_saida come from the queue head, registered storage.
  - instr_saida=0 and pc_saida=0 when the queue is empty.
- Pop: occurs when valido && pronto and removes the head at the clock edge.
- Push: occurs when state=BUSCANDO, desvio=0, and (count<PROF or pop this cycle).
  - Writes {pc_busca, instrucao_mem} at the tail.
  - pc_busca <= pc_busca+1 on the same edge.
  - Fetch latency is zero cycles; a pushed word is visible on instr_saida the next cycle if the queue was empty.
- Full queue:
  - With no pop, there is no push and pc_busca holds.
  - A simultaneous push and pop while full is allowed, and count is unchanged.
- Empty queue: valido=0 and pronto is ignored.
- Redirect (desvio=1), which has priority over push:
  - A pop in the same cycle still completes; decode has consumed that word.
  - All entries are discarded, count <= 0.
  - pc_busca <= alvo, and no push occurs this cycle.
  - State <= BUSCANDO if alvo < TAM_MEM, else FIM.
  - The first post-redirect word appears on the second edge after desvio.
- State machine:
  - BUSCANDO -> FIM when a push occurs with pc_busca+1 >= TAM_MEM, or at any edge where pc_busca >= TAM_MEM.
  - FIM: no pushes, pc_busca holds, and the queue drains normally.
  - FIM -> BUSCANDO only on desvio with alvo < TAM_MEM.
- parado = (state==FIM && count==0), registered, updated on the same edge as state and count.
- Arithmetic:
  - pc_busca is unsigned 64-bit, and the increment wraps modulo 2^64.
  - Comparisons against TAM_MEM are unsigned.
  - Queue read/write pointers are log2(PROF) bits and wrap; count is log2(PROF)+1 bits.
- Back-to-back desvio pulses: each one is honoured independently, and the last target wins.

Test Plan:
- Streaming, with ROM word 1 = 0x00702083 and pronto=1 held after reset → on consecutive cycles, (pc_saida, instr_saida) = (0, 0x00000000), then (1, 0x00702083), then 2, 3, …, with valido continuously 1 after the first edge.
- Backpressure, pronto=0 for 5 cycles → count saturates at 2, pc_mem holds at 2, and head stays pc 0; then raising pronto resumes with pc 0, 1, 2 and no gaps or duplicates.
- Redirect: pulse desvio with alvo=10 while the queue holds pc 4 and pc 5 → queue flushed, the cycle after next shows pc_saida=10, then 11, 12, …; pc 4 and pc 5 never appear after the flush (unless accepted in the desvio cycle).
- End of memory, TAM_MEM=64, pronto=1 → last delivered pc=63 and pc_mem holds 64; parado=1 one cycle after pc 63 is popped; a later desvio with alvo=8 clears parado and delivers pc 8 onward.
- Out-of-range redirect, desvio with alvo=100 → no pushes, valido falls to 0, and parado=1 on the next edge.
- Asynchronous reset mid-stream, reset_n pulsed low between edges while the queue is full → valido, parado and pc_mem go to 0 immediately; after release, streaming restarts at pc 0.

Source files
------------

// File: rtl/unidade_busca.sv
// Instruction-fetch front end: drives the fetch PC into the instruction ROM,
// queues {pc, word} pairs for decode and handles branch redirects from execute.
module unidade_busca #(
  parameter int PROF    = 2,
  parameter int TAM_MEM = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [63:0] pc_mem,
  input  logic [31:0] instrucao_mem,
  output logic [31:0] instr_saida,
  output logic [63:0] pc_saida,
  output logic        valido,
  input  logic        pronto,
  input  logic        desvio,
  input  logic [63:0] alvo,
  output logic        parado
);

  localparam int            PW     = (PROF > 1) ? $clog2(PROF) : 1;
  localparam logic [PW:0]   PROF_C = (PW + 1)'(PROF);
  localparam logic [63:0]   LIMITE = 64'(TAM_MEM);

  typedef enum logic {BUSCANDO, FIM} estado_t;

  estado_t       estado, estado_prox;
  logic [63:0]   pc_busca, pc_prox, pc_inc;
  logic [PW:0]   conta, conta_prox;
  logic [PW-1:0] ptr_le, ptr_esc;
  logic          pop, push;

  logic [31:0]   fila_instr [PROF];
  logic [63:0]   fila_pc    [PROF];

  assign pc_mem      = pc_busca;
  assign valido      = (conta != '0);
  assign instr_saida = valido ? fila_instr[ptr_le] : '0;
  assign pc_saida    = valido ? fila_pc[ptr_le]    : '0;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred; blocking '=' is correct here.
  always_comb begin
    pc_inc      = pc_busca + 64'd1;
    pop         = valido && pronto;
    push        = (estado == BUSCANDO) && !desvio && ((conta < PROF_C) || pop);
    estado_prox = estado;
    pc_prox     = pc_busca;
    conta_prox  = conta;
    if (desvio) begin
      // Redirect wins over push; a same-cycle pop is simply absorbed by the flush.
      estado_prox = (alvo < LIMITE) ? BUSCANDO : FIM;
      pc_prox     = alvo;
      conta_prox  = '0;
    end else begin
      if (push) pc_prox = pc_inc;
      conta_prox = conta + (PW + 1)'(push) - (PW + 1)'(pop);
      if (estado == BUSCANDO && ((push && pc_inc >= LIMITE) || pc_busca >= LIMITE))
        estado_prox = FIM;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado   <= BUSCANDO;
      pc_busca <= '0;
      conta    <= '0;
      parado   <= 1'b0;
    end else begin
      estado   <= estado_prox;
      pc_busca <= pc_prox;
      conta    <= conta_prox;
      parado   <= (estado_prox == FIM) && (conta_prox == '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_le  <= '0;
      ptr_esc <= '0;
    end else if (desvio) begin
      ptr_le  <= '0;
      ptr_esc <= '0;
    end else begin
      if (pop)  ptr_le  <= ptr_le + 1'b1;
      if (push) ptr_esc <= ptr_esc + 1'b1;
    end
  end

  // NOTE: the queue storage is cleared on reset too; it is only a few entries
  // and it guarantees nothing from before reset can ever reach decode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PROF; i++) begin
        fila_instr[i] <= '0;
        fila_pc[i]    <= '0;
      end
    end else if (push) begin
      fila_instr[ptr_esc] <= instrucao_mem;
      fila_pc[ptr_esc]    <= pc_busca;
    end
  end

endmodule
